uart_time_cmd_parser: RTL
=========================

UART_TIME_CMD_PARSER -- requirements
Module: uart_time_cmd_parser

Interface
REQ-001 Parameter CLOCK_FREQ, default 50000000, clock frequency in Hz.
REQ-002 Parameter TIMEOUT_CYCLES, default CLOCK_FREQ (1 s), inter-byte timeout in clk cycles; valid range is 2 or more.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx_data  input  8  received byte from the UART receiver stage.
REQ-006 rx_valid  input  1  byte strobe; each clk cycle with rx_valid=1 is one accepted byte.
REQ-007 set_hours  output  5  parsed hours, binary 0-23.
REQ-008 set_minutes  output  6  parsed minutes, binary 0-59.
REQ-009 set_seconds  output  6  parsed seconds, binary 0-59.
REQ-010 set_load  output  1  one-cycle pulse; set_* values are valid for loading into the clock core.
REQ-011 cmd_error  output  1  one-cycle pulse on a rejected or aborted command.
REQ-012 busy  output  1  high while a command is in progress (state not IDLE).

Function
REQ-013 Command format SHALL be ASCII 'T' (0x54), six digits H1 H0 M1 M0 S1 S0, then CR (0x0D).
REQ-014 FSM states SHALL be IDLE, H10, H1, M10, M1, S10, S1, TERM, advancing one state per accepted byte.
REQ-015 IDLE: 'T' moves the FSM to H10; every other byte is ignored silently, with no error.
REQ-016 Digit checks: H10 accepts '0'-'2'. H1 accepts '0'-'9', but only '0'-'3' when H10='2'. M10 and S10 accept '0'-'5'. M1 and S1 accept '0'-'9'.
REQ-017 TERM accepts only CR.
REQ-018 On any byte that fails its check, other than 'T', the FSM SHALL return to IDLE and pulse cmd_error.
REQ-019 On 'T' in any non-IDLE state, the FSM SHALL pulse cmd_error and restart at H10.
REQ-020 Digit values SHALL be captured as rx_data-0x30 into 4-bit registers.
REQ-021 Binary values SHALL be computed as tens*10+ones, truncated to the output width.
REQ-022 On CR in TERM, set_hours, set_minutes and set_seconds SHALL be updated and set_load pulsed, both on the clock edge that samples the CR byte.
REQ-023 Load latency: set_load SHALL be high in the cycle after the CR rx_valid cycle, for exactly 1 cycle.
REQ-024 The FSM SHALL be in IDLE in that same cycle.
REQ-025 set_* SHALL hold their values between loads; a rejected command SHALL never modify set_*.
REQ-026 cmd_error SHALL assert in the cycle after the offending byte, or after timeout expiry, for exactly 1 cycle.
REQ-027 The timeout counter SHALL clear on every accepted byte.
REQ-028 The timeout counter SHALL increment while not IDLE and hold at 0 in IDLE.
REQ-029 When the count reaches TIMEOUT_CYCLES-1 outside IDLE, the FSM SHALL return to IDLE and pulse cmd_error.
REQ-030 If rx_valid is high in the same cycle the timeout expires, the byte SHALL win: it is processed normally, the counter clears, and no timeout error is raised.
REQ-031 Back-to-back rx_valid on consecutive cycles SHALL be processed as consecutive bytes with no byte dropped.
REQ-032 set_load and cmd_error SHALL never be asserted in the same cycle.

Reset
REQ-033 While reset=1, the FSM SHALL go to IDLE and clear the digit registers and timeout counter.
REQ-034 While reset=1, set_hours, set_minutes and set_seconds SHALL go to 0.
REQ-035 While reset=1, set_load, cmd_error and busy SHALL go to 0.
REQ-036 Reset SHALL take priority over rx_valid.
REQ-037 Reset mid-command SHALL discard the partial command with no cmd_error and no set_load.
REQ-038 After reset deasserts, the first accepted byte SHALL be interpreted from IDLE.

Verification
REQ-039 Basic load: "T123456\r" -> one set_load pulse, hours=12, minutes=34, seconds=56, busy=0 after the pulse.
REQ-040 Maximum time: "T235959\r" then "T000000\r" -> hours/minutes/seconds read 23/59/59 after the first load, then 0/0/0 after the second.
REQ-041 Range check: "T240000\r" -> cmd_error at the '4' byte, no set_load, set_* unchanged; the trailing "0000\r" is ignored.
REQ-042 Timeout: with TIMEOUT_CYCLES=100, send "T12" then idle 100 cycles -> one cmd_error, busy=0, no load.
REQ-043 Resync: "T12T083000\r" -> cmd_error at the second 'T', then set_load with hours=8, minutes=30, seconds=0.
REQ-044 Reset mid-command: assert reset for 1 cycle after "T1234" -> all outputs 0, no pulses; a following "T010203\r" loads 1/2/3.

Source files
------------

// File: rtl/uart_time_cmd_parser.sv
// uart_time_cmd_parser
// Parses "Thhmmss<CR>" from a byte stream and presents the time as binary
// fields with a one-cycle load strobe. Malformed or stalled commands are
// dropped with a one-cycle error strobe. A 'T' always (re)starts a command.
module uart_time_cmd_parser #(
   parameter int CLOCK_FREQ     = 50000000,
   parameter int TIMEOUT_CYCLES = CLOCK_FREQ
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [4:0] set_hours,
   output logic [5:0] set_minutes,
   output logic [5:0] set_seconds,
   output logic       set_load,
   output logic       cmd_error,
   output logic       busy
);

   // Counter holds 0..TIMEOUT_CYCLES-1; expiry is detected on the last value.
   localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};

   localparam logic [7:0] CHAR_T  = 8'h54;
   localparam logic [7:0] CHAR_CR = 8'h0D;

   // Encoding is sequential so a good byte advances with state_r + 1.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      H10  = 3'd1,
      H1   = 3'd2,
      M10  = 3'd3,
      M1   = 3'd4,
      S10  = 3'd5,
      S1   = 3'd6,
      TERM = 3'd7
   } state_t;

   state_t           state_r, state_s;
   logic [CNT_W-1:0] cnt_r, cnt_s;
   logic [3:0]       h10_r, h1_r, m10_r, m1_r, s10_r, s1_r;
   logic             err_s, load_s, cap_s, ok_s, is_digit_s;
   logic [3:0]       digit_s;

   // For an ASCII digit the low nibble equals rx_data - 0x30.
   assign is_digit_s = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign digit_s    = rx_data[3:0];
   assign busy       = (state_r != IDLE);

   // Next-state, byte validation, strobes and timeout counter.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      err_s   = 1'b0;
      load_s  = 1'b0;
      cap_s   = 1'b0;
      ok_s    = 1'b0;

      case (state_r)
         H10:      ok_s = is_digit_s && (digit_s <= 4'd2);
         H1:       ok_s = is_digit_s && ((h10_r != 4'd2) || (digit_s <= 4'd3));
         M10, S10: ok_s = is_digit_s && (digit_s <= 4'd5);
         M1, S1:   ok_s = is_digit_s;
         TERM:     ok_s = (rx_data == CHAR_CR);
         default:  ok_s = 1'b0;
      endcase

      if (rx_valid) begin
         // A byte always clears the counter, even on the expiry cycle.
         cnt_s = CNT_ZERO;
         if (rx_data == CHAR_T) begin
            state_s = H10;
            err_s   = (state_r != IDLE);
         end else if (state_r == IDLE) begin
            state_s = IDLE;
         end else if (!ok_s) begin
            state_s = IDLE;
            err_s   = 1'b1;
         end else if (state_r == TERM) begin
            state_s = IDLE;
            load_s  = 1'b1;
         end else begin
            state_s = state_t'(state_r + 3'd1);
            cap_s   = 1'b1;
         end
      end else if (state_r != IDLE) begin
         if (cnt_r == CNT_LAST) begin
            state_s = IDLE;
            err_s   = 1'b1;
            cnt_s   = CNT_ZERO;
         end else begin
            state_s = state_r;
            cnt_s   = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         state_s = IDLE;
         cnt_s   = CNT_ZERO;
      end
   end

   // State, timeout counter and digit capture registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         h10_r   <= 4'd0;
         h1_r    <= 4'd0;
         m10_r   <= 4'd0;
         m1_r    <= 4'd0;
         s10_r   <= 4'd0;
         s1_r    <= 4'd0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         if (cap_s) begin
            case (state_r)
               H10:     h10_r <= digit_s;
               H1:      h1_r  <= digit_s;
               M10:     m10_r <= digit_s;
               M1:      m1_r  <= digit_s;
               S10:     s10_r <= digit_s;
               S1:      s1_r  <= digit_s;
               default: ;
            endcase
         end
      end
   end

   // Registered strobes and time outputs; set_* change only on a load.
   always_ff @(posedge clk) begin
      if (reset) begin
         set_load    <= 1'b0;
         cmd_error   <= 1'b0;
         set_hours   <= 5'd0;
         set_minutes <= 6'd0;
         set_seconds <= 6'd0;
      end else begin
         set_load  <= load_s;
         cmd_error <= err_s;
         if (load_s) begin
            set_hours   <= (5'(h10_r) * 5'd10) + 5'(h1_r);
            set_minutes <= (6'(m10_r) * 6'd10) + 6'(m1_r);
            set_seconds <= (6'(s10_r) * 6'd10) + 6'(s1_r);
         end
      end
   end

endmodule
